// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, round count, S-box and GF(2^8) doubling.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Byte 0x00 occupies the top byte of the vector.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / ciphertext-out handshake bundle plus status for the AES round controller.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block, busy, round
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block, busy, round
  );
endinterface

// File: rtl/MixColumns.sv
// AES MixColumns: each column multiplied by the fixed {02,03,01,01} circulant, combinational.
module MixColumns
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = state_in[127-32*c -: 8];
    assign w_a1 = state_in[119-32*c -: 8];
    assign w_a2 = state_in[111-32*c -: 8];
    assign w_a3 = state_in[103-32*c -: 8];
    assign state_out[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign state_out[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign state_out[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign state_out[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end
endmodule

// File: rtl/ShiftRows.sv
// AES ShiftRows: row r rotated left by r bytes, column-major byte layout.
module ShiftRows (
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[127-8*(r+4*c) -: 8] = state_in[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end
endmodule

// File: rtl/SubBytes.sv
// AES SubBytes: S-box applied to each of the 16 state bytes, combinational.
module SubBytes
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_out[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
  end
endmodule

// File: rtl/aes_key_step.sv
// Combinational AES-128 key expansion step: current round key and rcon to the next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_nk
);
  logic [31:0] w_rot;
  logic [31:0] w_tmp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_rot = {i_rk[23:0], i_rk[31:24]};
  assign w_tmp = {sbox(w_rot[31:24]) ^ i_rcon, sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  assign w_n0 = i_rk[127:96] ^ w_tmp;
  assign w_n1 = i_rk[95:64]  ^ w_n0;
  assign w_n2 = i_rk[63:32]  ^ w_n1;
  assign w_n3 = i_rk[31:0]   ^ w_n2;
  assign o_nk = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor, one round per clock: ciphertext valid 11 cycles after accept, held until out_ready.
// in_ready is low while busy; AES_CTRL_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef AES_CTRL_ABORT_EN
  input  logic abort,
`endif
  aes_round_ctrl_if.slave bus
);
  state_e       r_state, w_state_nxt;
  logic         r_rst_q;
  logic [127:0] r_data;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;

  logic         w_in_ready, w_accept, w_last, w_abort;
  logic [127:0] w_nk, w_sb, w_sr, w_mc, w_round_out;

  // r_rst_q keeps in_ready low for as long as rst is held, without a path from rst itself.
  assign w_in_ready = (r_state == IDLE) && !r_rst_q;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_round == 4'(NR));

`ifdef AES_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  aes_key_step u_key_step (.i_rk(r_rk), .i_rcon(r_rcon), .o_nk(w_nk));
  SubBytes     u_sub_bytes (.state_in(r_data), .state_out(w_sb));
  ShiftRows    u_shift_rows (.state_in(w_sb), .state_out(w_sr));
  MixColumns   u_mix_columns (.state_in(w_sr), .state_out(w_mc));

  assign w_round_out = (w_last ? w_sr : w_mc) ^ w_nk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rst_q <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rst_q <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_data  <= '0;
      r_rk    <= '0;
      r_rcon  <= RCON_INIT;
      r_round <= '0;
    end else if (w_accept) begin
      r_data  <= bus.in_block ^ bus.in_key;
      r_rk    <= bus.in_key;
      r_rcon  <= RCON_INIT;
      r_round <= 4'd1;
    end else if (r_state == RUN) begin
      r_data <= w_round_out;
      r_rk   <= w_nk;
      r_rcon <= xtime(r_rcon);
      if (!w_last) r_round <= r_round + 4'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_block = r_data;
  assign bus.busy      = (r_state != IDLE);
  assign bus.round     = r_round;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed plus randomized bench for aes_round_ctrl against a byte-array AES-128 reference model.
module tb_aes_round_ctrl;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [7:0]   sb [256];
  logic [127:0] rnd_pt, rnd_key;

  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();

`ifdef AES_CTRL_ABORT_EN
  logic abort = 1'b0;
  aes_round_ctrl dut (.clk(clk), .rst(rst), .abort(abort), .bus(bus));
`else
  aes_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w[0] = sb[k[13]] ^ rc;
      w[1] = sb[k[14]];
      w[2] = sb[k[15]];
      w[3] = sb[k[12]];
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ w[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = t[row + 4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c+0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check_b(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!bus.in_ready && g < 30) begin
      step();
      g++;
    end
    check_i({tag, "_rdy"}, int'(bus.in_ready), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check_i("rst_flags", int'({bus.in_ready, bus.out_valid, bus.busy}), 0);
    check_i("rst_round", int'(bus.round), 0);
    check_b("rst_block", bus.out_block, '0);
    rst = 1'b0;
    step();
    check_i("rst_release_rdy", int'(bus.in_ready), 1);
  endtask

  // One block: accept, check latency and ciphertext, optionally stall the sink for `hold` cycles.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold);
    int k;
    logic [127:0] held;
    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.in_block  = pt;
    bus.in_key    = key;
    bus.out_ready = (hold == 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_block = {$urandom, $urandom, $urandom, $urandom};
    bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
    k = 1;
    check_i({tag, "_run1"}, int'({bus.busy, bus.in_ready, bus.round}), int'({1'b1, 1'b0, 4'd1}));
    while (!bus.out_valid && k < 30) begin
      step();
      k++;
    end
    check_i({tag, "_latency"}, k, 11);
    check_b({tag, "_ct"}, bus.out_block, exp);
    held = bus.out_block;
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.in_block = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < hold; i++) begin
        step();
        check_i({tag, "_hold_flags"}, int'({bus.out_valid, bus.in_ready}), 2);
        check_b({tag, "_hold_block"}, bus.out_block, held);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    step();
    check_i({tag, "_release"}, int'({bus.out_valid, bus.in_ready, bus.busy}), 2);
  endtask

  task automatic back_to_back();
    int acc[$];
    logic [127:0] exp_q[$];
    int n_out = 0;
    int n_acc = 0;
    bit pend = 1'b0;
    exp_q = {B_CT, C_CT};
    wait_ready("b2b");
    bus.in_block  = B_PT;
    bus.in_key    = B_KEY;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      if (pend) begin
        bus.in_block = C_PT;
        bus.in_key   = C_KEY;
        if (n_acc == 2) bus.in_valid = 1'b0;
        pend = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc.push_back(cyc);
        n_acc++;
        pend = 1'b1;
      end
      if (bus.out_valid) begin
        check_b($sformatf("b2b_ct%0d", n_out), bus.out_block, exp_q[n_out]);
        n_out++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    check_i("b2b_outputs", n_out, 2);
    check_i("b2b_gap", (acc.size() >= 2) ? acc[1] - acc[0] : -1, 12);
  endtask

  task automatic reset_mid();
    int g = 0;
    int seen = 0;
    wait_ready("mid");
    bus.in_valid  = 1'b1;
    bus.in_block  = B_PT;
    bus.in_key    = B_KEY;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    while (bus.round != 4'd5 && g < 20) begin
      step();
      g++;
    end
    check_i("mid_round5", int'(bus.round), 5);
    rst = 1'b1;
    step();
    check_i("mid_in_rst", int'({bus.busy, bus.out_valid, bus.in_ready, bus.round}), 0);
    rst = 1'b0;
    step();
    check_i("mid_after_rst", int'({bus.in_ready, bus.busy}), 2);
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check_i("mid_no_output", seen, 0);
    run_block("mid_next", B_PT, B_KEY, B_CT, 0);
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic abort_mid();
    int g = 0;
    int seen = 0;
    wait_ready("abort");
    bus.in_valid  = 1'b1;
    bus.in_block  = C_PT;
    bus.in_key    = C_KEY;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    while (bus.round != 4'd3 && g < 20) begin
      step();
      g++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_i("abort_idle", int'({bus.busy, bus.out_valid, bus.in_ready}), 1);
    check_b("abort_cleared", bus.out_block, '0);
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check_i("abort_no_output", seen, 0);
    run_block("abort_next", B_PT, B_KEY, B_CT, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    build_sbox();
    @(negedge clk);
    do_reset();
    run_block("appB", B_PT, B_KEY, B_CT, 0);
    run_block("appC1", C_PT, C_KEY, C_CT, 0);
    run_block("bp", B_PT, B_KEY, B_CT, 20);
    back_to_back();
    reset_mid();
`ifdef AES_CTRL_ABORT_EN
    abort_mid();
`endif
    for (int n = 0; n < 6; n++) begin
      rnd_pt  = {$urandom, $urandom, $urandom, $urandom};
      rnd_key = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rnd%0d", n), rnd_pt, rnd_key, aes_model(rnd_pt, rnd_key),
                int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
